// File: rtl/bfm_ahbl_to_apb.sv
// AHB-Lite to APB3 bus functional bridge: one APB transfer per AHB transfer,
// with APB wait states and slave errors reflected back as AHB wait/ERROR responses.
module bfm_ahbl_to_apb #(
    parameter int unsigned TPD = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        PSEL,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int unsigned ADDR_W    = 32;
    localparam logic [2:0]  MAX_HSIZE = 3'd2;
    // Output propagation delay is a simulation-side notion; the registers here carry no delay.
    localparam int unsigned TPD_UNUSED = TPD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic                accept_c;
    logic                size_ok_c;
    logic                htrans_seq_unused;

    assign htrans_seq_unused = HTRANS[0];
    assign accept_c  = HSEL && HTRANS[1] && HREADYIN && ((state == S_IDLE) || (state == S_ERR2));
    assign size_ok_c = (HSIZE <= MAX_HSIZE);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            HRDATA    <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            PSEL      <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PENABLE   <= 1'b0;
            PWDATA    <= '0;
        end else begin
            case (state)
                // Both IDLE and the second error cycle may accept a new address phase
                S_IDLE, S_ERR2: begin
                    state     <= S_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (accept_c) begin
                        addr_q    <= HADDR;
                        write_q   <= HWRITE;
                        HREADYOUT <= 1'b0;
                        if (size_ok_c) begin
                            state <= S_LATCH;
                        end else begin
                            state <= S_ERR1;
                            HRESP <= 1'b1;
                        end
                    end
                end
                // HWDATA is valid in the AHB data phase, i.e. this cycle
                S_LATCH: begin
                    if (write_q) begin
                        PWDATA <= HWDATA;
                    end
                    PADDR   <= addr_q;
                    PWRITE  <= write_q;
                    PSEL    <= 1'b1;
                    PENABLE <= 1'b0;
                    state   <= S_SETUP;
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            HRESP <= 1'b1;
                            state <= S_ERR1;
                        end else begin
                            HREADYOUT <= 1'b1;
                            if (!write_q) begin
                                HRDATA <= PRDATA;
                            end
                            state <= S_IDLE;
                        end
                    end
                end
                S_ERR1: begin
                    HRESP     <= 1'b1;
                    HREADYOUT <= 1'b1;
                    state     <= S_ERR2;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
